// File: rtl/elevator_call_latch.sv
// Call-button front end: 2-flop sync, per-floor debounce, rising-edge call latch and req pulses.
// Optional build macro CALL_REISSUE_EN periodically re-pulses still-pending calls.
module elevator_call_latch #(
  parameter int NUM_FLOORS      = 8,
  parameter int FLOOR_W         = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REISSUE_CYCLES  = 64
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_FLOORS-1:0]                 btn_raw,
  input  logic                                  emergency,
  input  logic [FLOOR_W-1:0]                    current_floor,
  input  logic                                  door_open,
  output logic [NUM_FLOORS-1:0]                 req_pulse,
  output logic [NUM_FLOORS-1:0]                 pending,
  output logic [$clog2(NUM_FLOORS+1)-1:0]       pending_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PC_W  = $clog2(NUM_FLOORS + 1);

  if (DEBOUNCE_CYCLES < 1 || REISSUE_CYCLES < 2 || (1 << FLOOR_W) < NUM_FLOORS) begin : g_param_check
    $error("elevator_call_latch: illegal parameter combination");
  end

  logic [NUM_FLOORS-1:0] sync1, sync2, deb, deb_d;
  logic [CNT_W-1:0]      deb_cnt [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] serviced, new_call, accept, reissue, pending_next, req_next;
  logic [PC_W-1:0]       count_next;

  always_comb begin
    serviced = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      serviced[i] = door_open && (current_floor == FLOOR_W'(i));
    end
  end

  assign new_call     = deb & ~deb_d;
  // Service wins over a call landing on the same edge; emergency drops new presses only.
  assign accept       = new_call & ~serviced & {NUM_FLOORS{~emergency}};
  assign pending_next = (pending & ~serviced) | accept;
  assign req_next     = accept | reissue;

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      count_next = count_next + PC_W'(pending_next[i]);
    end
  end

`ifdef CALL_REISSUE_EN
  localparam int RC_W = $clog2(REISSUE_CYCLES);
  logic [RC_W-1:0] reissue_cnt;
  logic            reissue_wrap;

  assign reissue_wrap = (reissue_cnt == RC_W'(REISSUE_CYCLES - 1));
  assign reissue      = (reissue_wrap && !emergency) ? (pending & ~serviced) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reissue_cnt <= '0;
    end else if (reissue_wrap) begin
      reissue_cnt <= '0;
    end else begin
      reissue_cnt <= reissue_cnt + 1'b1;
    end
  end
`else
  assign reissue = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      // Counter saturates at DEBOUNCE_CYCLES; the level flips on the following mismatched edge.
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_pulse     <= '0;
      pending       <= '0;
      pending_count <= '0;
    end else begin
      req_pulse     <= req_next;
      pending       <= pending_next;
      pending_count <= count_next;
    end
  end

endmodule

// File: tb/tb_elevator_call_latch.sv
// Self-checking bench for elevator_call_latch: directed scenarios plus random stimulus vs a history-based model.
module tb_elevator_call_latch;
  localparam int N   = 8;
  localparam int FW  = 3;
  localparam int DEB = 4;
  localparam int RE  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  btn_raw;
  logic          emergency;
  logic [FW-1:0] current_floor;
  logic          door_open;
  logic [N-1:0]  req_pulse;
  logic [N-1:0]  pending;
  logic [3:0]    pending_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  elevator_call_latch #(
    .NUM_FLOORS(N), .FLOOR_W(FW), .DEBOUNCE_CYCLES(DEB), .REISSUE_CYCLES(RE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .emergency(emergency),
    .current_floor(current_floor), .door_open(door_open),
    .req_pulse(req_pulse), .pending(pending), .pending_count(pending_count)
  );

  // Reference model: debounced level flips once the synced button (btn two edges old)
  // has disagreed with it on DEB+1 consecutive edges.
  logic [N-1:0] bhist[$];
  logic [N-1:0] m_deb, m_deb_prev, m_pend, m_req;
  int           m_rc;

  function automatic void model_reset();
    bhist.delete();
    m_deb = '0; m_deb_prev = '0; m_pend = '0; m_req = '0; m_rc = 0;
  endfunction

  function automatic void model_edge();
    logic [N-1:0] new_deb, nc, serv, acc, reis;
    int L = bhist.size();
    new_deb = m_deb;
    for (int i = 0; i < N; i++) begin
      bit flip = 1'b1;
      for (int k = 0; k <= DEB; k++) begin
        int idx = L - 2 - k;
        logic b = (idx >= 0) ? bhist[idx][i] : 1'b0;
        if (b == m_deb[i]) flip = 1'b0;
      end
      if (flip) new_deb[i] = ~m_deb[i];
    end
    nc   = m_deb & ~m_deb_prev;
    serv = door_open ? (N'(1) << current_floor) : '0;
    acc  = emergency ? '0 : (nc & ~serv);
    reis = '0;
`ifdef CALL_REISSUE_EN
    if (m_rc == RE - 1 && !emergency) reis = m_pend & ~serv;
    m_rc = (m_rc + 1) % RE;
`endif
    m_req      = acc | reis;
    m_pend     = (m_pend & ~serv) | acc;
    m_deb_prev = m_deb;
    m_deb      = new_deb;
    bhist.push_back(btn_raw);
    if (bhist.size() > 16) void'(bhist.pop_front());
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic press(input logic [N-1:0] mask, input int hold,
                       output logic [N-1:0] seen, output int pulses);
    seen = '0; pulses = 0;
    btn_raw = mask;
    repeat (hold) begin
      step();
      seen |= req_pulse;
      if (req_pulse != '0) pulses++;
    end
    btn_raw = '0;
    repeat (10) begin
      step();
      seen |= req_pulse;
      if (req_pulse != '0) pulses++;
    end
  endtask

  task automatic test_reset();
    btn_raw = '0; emergency = 1'b0; door_open = 1'b0; current_floor = '0;
    do_reset();
    checks++; if (req_pulse !== 8'h00) begin errors++; $display("FAIL reset_req got=%h exp=00", req_pulse); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got=%h exp=00", pending); end
    checks++; if (pending_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", pending_count); end
  endtask

  task automatic test_latency();
    btn_raw = 8'h08;
    repeat (7) step();
    checks++; if (req_pulse !== 8'h00) begin errors++; $display("FAIL lat_early got=%h exp=00", req_pulse); end
    step();
    checks++; if (req_pulse !== 8'h08) begin errors++; $display("FAIL lat_pulse got=%h exp=08", req_pulse); end
    checks++; if (pending !== 8'h08) begin errors++; $display("FAIL lat_pending got=%h exp=08", pending); end
    checks++; if (pending_count !== 4'd1) begin errors++; $display("FAIL lat_count got=%0d exp=1", pending_count); end
    step();
    checks++; if (req_pulse !== 8'h00) begin errors++; $display("FAIL lat_drop got=%h exp=00", req_pulse); end
    btn_raw = '0;
    repeat (10) step();
  endtask

  task automatic test_bounce();
    int pulses2 = 0;
    logic seen2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn_raw = (i % 2) ? 8'h04 : 8'h00;
      step();
      seen2 |= req_pulse[2];
    end
    btn_raw = '0;
    repeat (12) begin step(); seen2 |= req_pulse[2]; end
    checks++; if (seen2 !== 1'b0) begin errors++; $display("FAIL bounce_req got=%b exp=0", seen2); end
    checks++; if (pending !== 8'h08) begin errors++; $display("FAIL bounce_pending got=%h exp=08", pending); end
    btn_raw = 8'h04;
    repeat (6) begin step(); if (req_pulse[2]) pulses2++; end
    btn_raw = '0;
    repeat (12) begin step(); if (req_pulse[2]) pulses2++; end
    checks++; if (pulses2 != 1) begin errors++; $display("FAIL bounce_hold6 pulses got=%0d exp=1", pulses2); end
    checks++; if (pending !== 8'h0c) begin errors++; $display("FAIL bounce_pending2 got=%h exp=0c", pending); end
  endtask

  task automatic test_service();
    logic [N-1:0] seen; int p;
    do_reset();
    press(8'h21, 10, seen, p);
    checks++; if (pending !== 8'h21) begin errors++; $display("FAIL svc_latch got=%h exp=21", pending); end
    current_floor = 3'd5; door_open = 1'b0;
    step();
    checks++; if (pending !== 8'h21) begin errors++; $display("FAIL svc_closed got=%h exp=21", pending); end
    door_open = 1'b1;
    step();
    door_open = 1'b0;
    checks++; if (pending !== 8'h01) begin errors++; $display("FAIL svc_clear got=%h exp=01", pending); end
    checks++; if (pending_count !== 4'd1) begin errors++; $display("FAIL svc_count got=%0d exp=1", pending_count); end
  endtask

  task automatic test_emergency();
    logic [N-1:0] seen; int p;
    emergency = 1'b1;
    press(8'h40, 10, seen, p);
    checks++; if (seen !== 8'h00) begin errors++; $display("FAIL emerg_pulse got=%h exp=00", seen); end
    checks++; if (pending !== 8'h01) begin errors++; $display("FAIL emerg_retain got=%h exp=01", pending); end
    emergency = 1'b0;
    press(8'h40, 10, seen, p);
    checks++; if (seen !== 8'h40 || p != 1) begin errors++; $display("FAIL emerg_after got=%h/%0d exp=40/1", seen, p); end
    checks++; if (pending !== 8'h41) begin errors++; $display("FAIL emerg_pending got=%h exp=41", pending); end
    checks++; if (pending_count !== 4'd2) begin errors++; $display("FAIL emerg_count got=%0d exp=2", pending_count); end
  endtask

  task automatic test_collision();
    logic [N-1:0] seen; int p;
    do_reset();
    current_floor = 3'd4; door_open = 1'b0; btn_raw = 8'h10;
    repeat (7) step();
    door_open = 1'b1;
    step();
    door_open = 1'b0;
    checks++; if (req_pulse[4] !== 1'b0) begin errors++; $display("FAIL collide_req got=%b exp=0", req_pulse[4]); end
    checks++; if (pending[4] !== 1'b0) begin errors++; $display("FAIL collide_pending got=%b exp=0", pending[4]); end
    btn_raw = '0;
    repeat (10) step();
    press(8'h18, 10, seen, p);
    checks++; if (pending !== 8'h18) begin errors++; $display("FAIL areset_pre got=%h exp=18", pending); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (pending !== 8'h00 || pending_count !== 4'd0 || req_pulse !== 8'h00) begin
      errors++; $display("FAIL areset_async pending=%h count=%0d req=%h exp=0", pending, pending_count, req_pulse);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reissue();
    logic [N-1:0] seen; int p, cnt, last, bad;
    int exp_cnt;
    do_reset();
    press(8'h82, 10, seen, p);
    checks++; if (pending !== 8'h82) begin errors++; $display("FAIL reissue_setup got=%h exp=82", pending); end
    cnt = 0; last = -1; bad = 0;
    for (int c = 0; c < 64; c++) begin
      step();
      if (req_pulse !== m_req) bad++;
      if (req_pulse != '0) begin
        if (req_pulse !== 8'h82 || (last >= 0 && c - last != RE)) bad++;
        cnt++; last = c;
      end
    end
`ifdef CALL_REISSUE_EN
    exp_cnt = 64 / RE;
`else
    exp_cnt = 0;
`endif
    checks++; if (cnt != exp_cnt || bad != 0) begin errors++; $display("FAIL reissue_run pulses got=%0d exp=%0d bad=%0d", cnt, exp_cnt, bad); end
    emergency = 1'b1; cnt = 0;
    repeat (64) begin step(); if (req_pulse != '0) cnt++; end
    emergency = 1'b0;
    checks++; if (cnt != 0) begin errors++; $display("FAIL reissue_emerg pulses got=%0d exp=0", cnt); end
    checks++; if (pending !== 8'h82) begin errors++; $display("FAIL reissue_hold got=%h exp=82", pending); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) btn_raw[i] = ~btn_raw[i];
      door_open     = ($urandom_range(3) == 0);
      current_floor = FW'($urandom_range(N - 1));
      if ($urandom_range(39) == 0) emergency = ~emergency;
      step();
      checks++; if (req_pulse !== m_req) begin errors++; $display("FAIL rand_req c=%0d got=%h exp=%h", c, req_pulse, m_req); end
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rand_pending c=%0d got=%h exp=%h", c, pending, m_pend); end
      checks++; if (pending_count !== 4'($countones(m_pend))) begin
        errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, pending_count, $countones(m_pend));
      end
    end
    emergency = 1'b0; door_open = 1'b0; btn_raw = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_service();
    test_emergency();
    test_collision();
    test_reissue();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
